hit_judge: RTL and testbench

Timing judge for the four-lane rhythm game. It consumes the one-cycle press pulses from the button debouncer and the note-spawn stream from the chart sequencer. For each press it decides PERFECT, GOOD or MISS against the note in flight on that lane, and maintains score, combo and max combo for the display stage.

---
 rtl/rhythm_pkg.sv | 21 ++
 rtl/hit_lane.sv | 86 ++++++++
 rtl/hit_judge.sv | 115 +++++++++++
 tb/tb_hit_judge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game judging path.
package rhythm_pkg;

  typedef enum logic [1:0] {
    MISS    = 2'd0,
    GOOD    = 2'd1,
    PERFECT = 2'd2
  } grade_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    WINDOW = 2'd2,
    RESULT = 2'd3
  } lane_state_t;

  localparam int unsigned PTS_PERFECT = 3;
  localparam int unsigned PTS_GOOD    = 1;
  localparam int unsigned NLANES      = 4;

endpackage

// File: rtl/hit_lane.sv
// One lane: note state, signed position counter and latched grade.
module hit_lane
  import rhythm_pkg::*;
#(
  parameter int TRAVEL_TICKS = 1000,
  parameter int PERFECT_WIN  = 30,
  parameter int GOOD_WIN     = 80,
  parameter int POS_W        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        tick,
  input  logic        spawn,
  input  logic        press,
  input  logic        grant,
  output lane_state_t state,
  output grade_t      grade
);

  localparam logic signed [POS_W-1:0] TRAVEL_POS  = POS_W'(TRAVEL_TICKS);
  localparam logic signed [POS_W-1:0] GOOD_POS    = POS_W'(GOOD_WIN);
  localparam logic signed [POS_W-1:0] MISS_POS    = POS_W'(-(GOOD_WIN + 1));
  localparam logic        [POS_W-1:0] PERFECT_MAG = POS_W'(PERFECT_WIN);

  logic signed [POS_W-1:0] pos, pos_nxt, pos_dec;
  logic        [POS_W-1:0] mag;
  lane_state_t             state_nxt;
  grade_t                  grade_nxt;

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    grade_nxt = grade;
    pos_dec   = pos - POS_W'(1);
    mag       = pos[POS_W-1] ? POS_W'(-pos) : POS_W'(pos);
    unique case (state)
      IDLE: begin
        if (spawn) begin
          state_nxt = FLIGHT;
          pos_nxt   = TRAVEL_POS;
        end
      end
      FLIGHT: begin
        if (tick) begin
          pos_nxt = pos_dec;
          if (pos_dec <= GOOD_POS) state_nxt = WINDOW;
        end
      end
      WINDOW: begin
        // A press wins over a same-cycle tick and is graded on the pre-tick position.
        if (press) begin
          grade_nxt = (mag <= PERFECT_MAG) ? PERFECT : GOOD;
          state_nxt = RESULT;
        end else if (tick) begin
          pos_nxt = pos_dec;
          if (pos_dec == MISS_POS) begin
            grade_nxt = MISS;
            state_nxt = RESULT;
          end
        end
      end
      RESULT: begin
        if (grant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pos   <= '0;
      grade <= MISS;
    end else if (clr) begin
      state <= IDLE;
      pos   <= '0;
      grade <= MISS;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      grade <= grade_nxt;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Four-lane timing judge: spawn routing, result arbitration, score and combo.
module hit_judge
  import rhythm_pkg::*;
#(
  parameter int TRAVEL_TICKS = 1000,
  parameter int PERFECT_WIN  = 30,
  parameter int GOOD_WIN     = 80,
  parameter int POS_W        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        tick,
  input  logic [3:0]  btn_pulse,
  input  logic        note_valid,
  input  logic [1:0]  note_lane,
  output logic        note_ready,
  output logic        judge_valid,
  output logic [1:0]  judge_lane,
  output logic [1:0]  judge_grade,
  output logic [15:0] score,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo
);

  lane_state_t       lane_state [NLANES];
  grade_t            lane_grade [NLANES];
  logic [NLANES-1:0] spawn;
  logic [NLANES-1:0] grant;
  logic              sel_any;
  logic [1:0]        sel_lane;
  grade_t            sel_grade;
  logic [16:0]       score_sum;
  logic [15:0]       score_nxt;
  logic [9:0]        combo_nxt;
  logic [9:0]        max_nxt;

  assign note_ready = (lane_state[note_lane] == IDLE);

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign spawn[i] = note_valid && note_ready && (note_lane == 2'(i));

    hit_lane #(
      .TRAVEL_TICKS(TRAVEL_TICKS),
      .PERFECT_WIN (PERFECT_WIN),
      .GOOD_WIN    (GOOD_WIN),
      .POS_W       (POS_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .tick (tick),
      .spawn(spawn[i]),
      .press(btn_pulse[i]),
      .grant(grant[i]),
      .state(lane_state[i]),
      .grade(lane_grade[i])
    );
  end

  always_comb begin
    grant    = '0;
    sel_any  = 1'b0;
    sel_lane = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (!sel_any && lane_state[i] == RESULT) begin
        grant[i] = 1'b1;
        sel_any  = 1'b1;
        sel_lane = 2'(i);
      end
    end
    sel_grade = lane_grade[sel_lane];
  end

  always_comb begin
    unique case (sel_grade)
      PERFECT: score_sum = {1'b0, score} + 17'(PTS_PERFECT);
      GOOD:    score_sum = {1'b0, score} + 17'(PTS_GOOD);
      default: score_sum = {1'b0, score};
    endcase
    score_nxt = score_sum[16] ? '1 : score_sum[15:0];
    if (sel_grade == MISS) combo_nxt = '0;
    else if (combo == '1)  combo_nxt = combo;
    else                   combo_nxt = combo + 10'd1;
    max_nxt = (combo_nxt > max_combo) ? combo_nxt : max_combo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_grade <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else if (clr) begin
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_grade <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
    end else begin
      judge_valid <= sel_any;
      if (sel_any) begin
        judge_lane  <= sel_lane;
        judge_grade <= sel_grade;
        score       <= score_nxt;
        combo       <= combo_nxt;
        max_combo   <= max_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Randomized plus directed scoreboard bench for hit_judge.
module tb_hit_judge;

  localparam int T  = 90;
  localparam int PW = 30;
  localparam int GW = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  btn_pulse = '0;
  logic        note_valid = 1'b0;
  logic [1:0]  note_lane = '0;
  logic        note_ready;
  logic        judge_valid;
  logic [1:0]  judge_lane;
  logic [1:0]  judge_grade;
  logic [15:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;

  hit_judge #(
    .TRAVEL_TICKS(T),
    .PERFECT_WIN (PW),
    .GOOD_WIN    (GW),
    .POS_W       (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .tick       (tick),
    .btn_pulse  (btn_pulse),
    .note_valid (note_valid),
    .note_lane  (note_lane),
    .note_ready (note_ready),
    .judge_valid(judge_valid),
    .judge_lane (judge_lane),
    .judge_grade(judge_grade),
    .score      (score),
    .combo      (combo),
    .max_combo  (max_combo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int lane;
    int grade;
    int score;
    int combo;
    int maxc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: per-lane occupancy, pending result and note position.
  bit occ  [4];
  bit pend [4];
  int pos  [4];
  int pg   [4];
  int m_score, m_combo, m_max;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      occ[i] = 0; pend[i] = 0; pos[i] = 0; pg[i] = 0;
    end
    m_score = 0; m_combo = 0; m_max = 0;
  endtask

  task automatic step(input bit t, input logic [3:0] b, input bit nv,
                      input logic [1:0] nl, input bit c);
    int g;
    int a;
    bit rdy;
    @(posedge clk); #1;
    tick = t; btn_pulse = b; note_valid = nv; note_lane = nl; clr = c;
    #1;
    rdy = !occ[nl];
    check("note_ready", int'(note_ready), int'(rdy));
    if (c) begin
      model_reset();
    end else begin
      g = -1;
      for (int i = 0; i < 4; i++) if (pend[i] && g < 0) g = i;
      for (int i = 0; i < 4; i++) begin
        if (occ[i] && !pend[i]) begin
          a = (pos[i] < 0) ? -pos[i] : pos[i];
          if (b[i] && a <= GW) begin
            pend[i] = 1;
            pg[i] = (a <= PW) ? 2 : 1;
          end else if (t) begin
            pos[i]--;
            if (pos[i] == -(GW + 1)) begin
              pend[i] = 1;
              pg[i] = 0;
            end
          end
        end
      end
      if (g >= 0) begin
        occ[g] = 0; pend[g] = 0;
        if (pg[g] == 0) m_combo = 0;
        else begin
          m_score = m_score + ((pg[g] == 2) ? 3 : 1);
          if (m_score > 65535) m_score = 65535;
          if (m_combo < 1023) m_combo++;
        end
        if (m_combo > m_max) m_max = m_combo;
        q.push_back('{cyc + 1, g, pg[g], m_score, m_combo, m_max});
      end
      if (nv && rdy) begin
        occ[nl] = 1;
        pos[nl] = T;
      end
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic hit4();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b1, 2'(i), 1'b0);
    run_ticks(T);
    step(1'b0, 4'b1111, 1'b0, 2'd0, 1'b0);
    idle(6);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(judge_valid), 0);
    check({tag, "_lane"},  int'(judge_lane), 0);
    check({tag, "_grade"}, int'(judge_grade), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_combo"}, int'(combo), 0);
    check({tag, "_max"},   int'(max_combo), 0);
    check({tag, "_ready"}, int'(note_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; tick = 1'b0; btn_pulse = '0; note_valid = 1'b0; clr = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every result strobe must match the scoreboard head at its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      while (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        check("judge_missing", 0, 1);
      end
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        check("judge_valid", int'(judge_valid), 1);
        check("judge_lane",  int'(judge_lane), e.lane);
        check("judge_grade", int'(judge_grade), e.grade);
        check("score",       int'(score), e.score);
        check("combo",       int'(combo), e.combo);
        check("max_combo",   int'(max_combo), e.maxc);
      end else begin
        check("judge_quiet", int'(judge_valid), 0);
      end
    end
  end

  initial begin
    logic [3:0] b;
    model_reset();
    @(posedge clk); #1;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Perfect hit at pos 0
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    run_ticks(T);
    step(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("t1_score", int'(score), 3);
    check("t1_combo", int'(combo), 1);

    // GOOD at pos 50, then an early press at 81 is ignored and the note misses
    step(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
    run_ticks(T - 50);
    step(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("t2_score", int'(score), 4);
    step(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
    run_ticks(T - 81);
    step(1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
    run_ticks(200);
    check("t2_combo", int'(combo), 0);
    check("t2_max", int'(max_combo), 2);

    // Four simultaneous presses drain in lane order
    hit4();
    check("t3_score", int'(score), 16);
    check("t3_combo", int'(combo), 4);

    // Press beats the miss at pos -80; a bare tick there misses
    step(1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    run_ticks(T + 80);
    step(1'b1, 4'b0010, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("t4_good_combo", int'(combo), 5);
    step(1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    run_ticks(T + 80);
    step(1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("t4_miss_combo", int'(combo), 0);

    // Occupied-lane spawn refused; press on idle lane ignored
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("t5_ready_busy", int'(note_ready), 0);
    step(1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    run_ticks(T + 90);
    idle(3);

    // Combo 5, then asynchronous reset mid-flight
    hit4();
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    run_ticks(T);
    step(1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
    idle(3);
    check("t6_combo5", int'(combo), 5);
    step(1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    run_ticks(20);
    do_reset();

    // Same again, then synchronous clr with a spawn in the same cycle
    hit4();
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    run_ticks(T);
    step(1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
    idle(3);
    step(1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    run_ticks(20);
    step(1'b1, 4'b0010, 1'b1, 2'd2, 1'b1);
    idle(1);
    check_zero("clr");

    // Combo saturation
    for (int r = 0; r < 260; r++) hit4();
    check("sat_combo", int'(combo), 1023);
    check("sat_max", int'(max_combo), 1023);

    // Randomized traffic
    for (int n = 0; n < 15000; n++) begin
      b = '0;
      for (int i = 0; i < 4; i++)
        if (occ[i] && !pend[i] && pos[i] <= GW && ($urandom % 12) == 0) b[i] = 1'b1;
      if (($urandom % 80) == 0) b[$urandom % 4] = 1'b1;
      step(($urandom % 4) != 0, b, ($urandom % 6) == 0, 2'($urandom % 4),
           ($urandom % 3000) == 0);
    end
    idle(10);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
